mult_arb: RTL and testbench

- Round-robin arbiter and sequencer that shares one sequential shift-add multiplier (mult) among N_REQ requesters.
- Captures a winning requester's operands and signedness flags, and holds them stable on the multiplier inputs for the whole operation; the multiplier samples its operands every cycle, not only at start.
- Pulses start, waits for the multiplier's busy to fall, then returns the product tagged with the requester id.
- Sits between client engines and a single mult instance.

---
 rtl/mult_arb.sv | 175 +++++++++++++++++
 tb/tb_mult_arb.sv | 470 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mult_arb.sv
// mult_arb: round-robin arbiter that shares one sequential shift-add multiplier
// among N_REQ requesters. The winner's operands are latched and held on the
// multiplier inputs for the whole operation; the product is returned tagged
// with the owning requester id. Every output is driven straight from a register.
module mult_arb #(
    parameter int unsigned N_REQ    = 3,
    parameter int unsigned BW_ID    = 2,
    parameter int unsigned BW_MCAND = 3,
    parameter int unsigned BW_MLIER = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [N_REQ-1:0]              req,
    input  logic [N_REQ*BW_MCAND-1:0]     req_mcand,
    input  logic [N_REQ*BW_MLIER-1:0]     req_mlier,
    input  logic [N_REQ-1:0]              req_mcand_is_signed,
    input  logic [N_REQ-1:0]              req_mlier_is_signed,
    output logic [N_REQ-1:0]              req_ack,
    output logic                          rsp_valid,
    output logic [BW_ID-1:0]              rsp_id,
    output logic [BW_MCAND+BW_MLIER-1:0]  rsp_prod,
    output logic                          mult_start,
    output logic [BW_MCAND-1:0]           mult_mcand,
    output logic [BW_MLIER-1:0]           mult_mlier,
    output logic                          mult_mcand_is_signed,
    output logic                          mult_mlier_is_signed,
    input  logic                          mult_busy,
    input  logic [BW_MCAND+BW_MLIER-1:0]  mult_prod
);

    localparam int unsigned BW_PROD = BW_MCAND + BW_MLIER;

    typedef enum logic [1:0] {
        IDLE,
        START,
        RUN,
        DONE
    } state_t;

    state_t               state_q, state_d;
    logic [BW_ID-1:0]     ptr_q, ptr_d;
    logic [BW_ID-1:0]     id_q, id_d;
    logic [N_REQ-1:0]     ack_q, ack_d;
    logic                 start_q, start_d;
    logic [BW_MCAND-1:0]  mcand_q, mcand_d;
    logic [BW_MLIER-1:0]  mlier_q, mlier_d;
    logic                 mcs_q, mcs_d;
    logic                 mls_q, mls_d;
    logic                 rsp_valid_q, rsp_valid_d;
    logic [BW_ID-1:0]     rsp_id_q, rsp_id_d;
    logic [BW_PROD-1:0]   rsp_prod_q, rsp_prod_d;

    // Arbitration scratch: requests rotated so bit 0 is the pointer position.
    logic [2*N_REQ-1:0]   req_dbl;
    logic [N_REQ-1:0]     req_rot;
    logic                 found;
    int unsigned          off;
    int unsigned          win;
    logic [BW_MCAND-1:0]  sel_mcand;
    logic [BW_MLIER-1:0]  sel_mlier;
    logic [N_REQ-1:0]     sel_mcs_vec;
    logic [N_REQ-1:0]     sel_mls_vec;

    // Round-robin pick: first set request at or after the pointer, with wrap.
    always_comb begin
        req_dbl     = {req, req};
        req_rot     = N_REQ'(req_dbl >> ptr_q);
        found       = 1'b0;
        off         = 0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            if (!found && req_rot[k]) begin
                found = 1'b1;
                off   = k;
            end
        end
        win = 32'(ptr_q) + off;
        if (win >= N_REQ) begin
            win = win - N_REQ;
        end
        sel_mcand   = BW_MCAND'(req_mcand >> (win * BW_MCAND));
        sel_mlier   = BW_MLIER'(req_mlier >> (win * BW_MLIER));
        sel_mcs_vec = req_mcand_is_signed >> win;
        sel_mls_vec = req_mlier_is_signed >> win;
    end

    // Sequencer next-state: grant, start pulse, wait for busy to fall, respond.
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        id_d        = id_q;
        ack_d       = '0;
        start_d     = 1'b0;
        mcand_d     = mcand_q;
        mlier_d     = mlier_q;
        mcs_d       = mcs_q;
        mls_d       = mls_q;
        rsp_valid_d = 1'b0;
        rsp_id_d    = rsp_id_q;
        rsp_prod_d  = rsp_prod_q;
        case (state_q)
            IDLE: begin
                if (found && !mult_busy) begin
                    ack_d   = N_REQ'(1) << win;
                    start_d = 1'b1;
                    mcand_d = sel_mcand;
                    mlier_d = sel_mlier;
                    mcs_d   = sel_mcs_vec[0];
                    mls_d   = sel_mls_vec[0];
                    id_d    = BW_ID'(win);
                    ptr_d   = (win + 1 >= N_REQ) ? '0 : BW_ID'(win + 1);
                    state_d = START;
                end
            end
            START: begin
                state_d = RUN;
            end
            RUN: begin
                if (!mult_busy) begin
                    rsp_valid_d = 1'b1;
                    rsp_id_d    = id_q;
                    rsp_prod_d  = mult_prod;
                    state_d     = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers; reset discards any operation in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            id_q        <= '0;
            ack_q       <= '0;
            start_q     <= 1'b0;
            mcand_q     <= '0;
            mlier_q     <= '0;
            mcs_q       <= 1'b0;
            mls_q       <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_prod_q  <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            id_q        <= id_d;
            ack_q       <= ack_d;
            start_q     <= start_d;
            mcand_q     <= mcand_d;
            mlier_q     <= mlier_d;
            mcs_q       <= mcs_d;
            mls_q       <= mls_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_prod_q  <= rsp_prod_d;
        end
    end

    assign req_ack              = ack_q;
    assign mult_start           = start_q;
    assign mult_mcand           = mcand_q;
    assign mult_mlier           = mlier_q;
    assign mult_mcand_is_signed = mcs_q;
    assign mult_mlier_is_signed = mls_q;
    assign rsp_valid            = rsp_valid_q;
    assign rsp_id               = rsp_id_q;
    assign rsp_prod             = rsp_prod_q;

endmodule

// File: tb/tb_mult_arb.sv
// tb_mult_arb: bench for mult_arb with a behavioural stand-in for the shared
// multiplier and a spec-level reference model (arithmetic products, cycle
// offsets and a round-robin pointer) for grants and responses.
module tb_mult_arb;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  req;
    logic [2:0]  mc [3];
    logic [3:0]  ml [3];
    logic [2:0]  sc;
    logic [2:0]  sl;
    logic [8:0]  req_mcand;
    logic [11:0] req_mlier;
    logic [2:0]  req_ack;
    logic        rsp_valid;
    logic [1:0]  rsp_id;
    logic [6:0]  rsp_prod;
    logic        mult_start;
    logic [2:0]  mult_mcand;
    logic [3:0]  mult_mlier;
    logic        mult_mcand_is_signed;
    logic        mult_mlier_is_signed;
    logic        mult_busy;
    logic [6:0]  mult_prod;

    logic        busy_force;
    int          mcnt = 0;
    logic [6:0]  mprod_q = '0;
    logic [6:0]  junk = '0;

    int vectors    = 0;
    int miscompares = 0;
    int cyc        = 0;

    typedef struct {
        int         cyc;
        int         id;
        logic [6:0] prod;
    } rsp_t;
    rsp_t exp_q[$];

    assign req_mcand = {mc[2], mc[1], mc[0]};
    assign req_mlier = {ml[2], ml[1], ml[0]};

    always #5 clk = ~clk;

    mult_arb #(
        .N_REQ   (3),
        .BW_ID   (2),
        .BW_MCAND(3),
        .BW_MLIER(4)
    ) dut (
        .clk                 (clk),
        .rst                 (rst),
        .req                 (req),
        .req_mcand           (req_mcand),
        .req_mlier           (req_mlier),
        .req_mcand_is_signed (sc),
        .req_mlier_is_signed (sl),
        .req_ack             (req_ack),
        .rsp_valid           (rsp_valid),
        .rsp_id              (rsp_id),
        .rsp_prod            (rsp_prod),
        .mult_start          (mult_start),
        .mult_mcand          (mult_mcand),
        .mult_mlier          (mult_mlier),
        .mult_mcand_is_signed(mult_mcand_is_signed),
        .mult_mlier_is_signed(mult_mlier_is_signed),
        .mult_busy           (mult_busy),
        .mult_prod           (mult_prod)
    );

    // Signed/unsigned product by plain integer arithmetic, truncated to 7 bits.
    function automatic logic [6:0] ref_prod(logic [2:0] a, logic [3:0] b, logic sa, logic sb);
        int x, y, p;
        x = int'(a);
        if (sa && a[2]) x = x - 8;
        y = int'(b);
        if (sb && b[3]) y = y - 16;
        p = x * y;
        return p[6:0];
    endfunction

    function automatic logic [2:0] onehot(int i);
        return 3'(1 << i);
    endfunction

    function automatic int pick(logic [2:0] r, int p);
        for (int k = 0; k < 3; k++) begin
            if (r[(p + k) % 3]) return (p + k) % 3;
        end
        return -1;
    endfunction

    // Multiplier stand-in: busy for 4 cycles after start, junk on prod while busy.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mcnt    <= 0;
            mprod_q <= '0;
        end else if (mult_start) begin
            mcnt <= 4;
        end else if (mcnt != 0) begin
            mcnt <= mcnt - 1;
            if (mcnt == 1)
                mprod_q <= ref_prod(mult_mcand, mult_mlier, mult_mcand_is_signed, mult_mlier_is_signed);
        end
    end

    always @(posedge clk) junk <= 7'($urandom);

    assign mult_busy = (mcnt != 0) || busy_force;
    assign mult_prod = (mcnt != 0) ? junk : mprod_q;

    task automatic tick;
        @(negedge clk);
        cyc++;
    endtask

    task automatic rand_ops(int i);
        mc[i] = 3'($urandom);
        ml[i] = 4'($urandom);
        sc[i] = 1'($urandom);
        sl[i] = 1'($urandom);
    endtask

    task automatic test_reset;
        rst = 1'b1;
        req = '0;
        busy_force = 1'b0;
        sc = '0;
        sl = '0;
        for (int i = 0; i < 3; i++) begin
            mc[i] = '0;
            ml[i] = '0;
        end
        tick;
        vectors++;
        if ({req_ack, rsp_valid, rsp_id, rsp_prod, mult_start, mult_mcand, mult_mlier,
             mult_mcand_is_signed, mult_mlier_is_signed} !== 23'd0) begin
            miscompares++;
            $display("FAIL reset_outputs: got %h expected 0", {req_ack, rsp_valid, rsp_id, rsp_prod,
                     mult_start, mult_mcand, mult_mlier, mult_mcand_is_signed, mult_mlier_is_signed});
        end
        tick;
        rst = 1'b0;
    endtask

    task automatic test_single_op(string nm, int idx, logic [2:0] a, logic [3:0] b, logic sa, logic sb);
        logic [6:0] ep;
        ep = ref_prod(a, b, sa, sb);
        mc[idx] = a;
        ml[idx] = b;
        sc[idx] = sa;
        sl[idx] = sb;
        req = onehot(idx);
        tick;
        vectors++;
        if ({req_ack, mult_start} !== {onehot(idx), 1'b1}) begin
            miscompares++;
            $display("FAIL %s_ack: got ack=%b start=%b expected ack=%b start=1", nm, req_ack, mult_start, onehot(idx));
        end
        vectors++;
        if ({mult_mcand, mult_mlier, mult_mcand_is_signed, mult_mlier_is_signed} !== {a, b, sa, sb}) begin
            miscompares++;
            $display("FAIL %s_operands: got %b/%b/%b/%b expected %b/%b/%b/%b", nm, mult_mcand, mult_mlier,
                     mult_mcand_is_signed, mult_mlier_is_signed, a, b, sa, sb);
        end
        req = '0;
        rand_ops(idx);
        for (int k = 1; k <= 5; k++) begin
            tick;
            vectors++;
            if ({req_ack, mult_start, rsp_valid} !== 5'b0) begin
                miscompares++;
                $display("FAIL %s_wait%0d: got ack=%b start=%b valid=%b expected all 0", nm, k, req_ack, mult_start, rsp_valid);
            end
        end
        tick;
        vectors++;
        if ({rsp_valid, rsp_id, rsp_prod} !== {1'b1, 2'(idx), ep}) begin
            miscompares++;
            $display("FAIL %s_rsp: got valid=%b id=%0d prod=%b expected valid=1 id=%0d prod=%b", nm, rsp_valid, rsp_id, rsp_prod, idx, ep);
        end
        tick;
        vectors++;
        if ({rsp_valid, rsp_id, rsp_prod} !== {1'b0, 2'(idx), ep}) begin
            miscompares++;
            $display("FAIL %s_rsp_hold: got valid=%b id=%0d prod=%b expected valid=0 id=%0d prod=%b", nm, rsp_valid, rsp_id, rsp_prod, idx, ep);
        end
    endtask

    task automatic test_operand_change;
        mc[0] = 3'd5;
        ml[0] = 4'd9;
        sc[0] = 1'b0;
        sl[0] = 1'b0;
        req = 3'b001;
        tick;
        vectors++;
        if (req_ack !== 3'b001) begin
            miscompares++;
            $display("FAIL opchg_ack: got %b expected 001", req_ack);
        end
        req = '0;
        mc[0] = 3'd2;
        ml[0] = 4'd3;
        sc[0] = 1'b1;
        sl[0] = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            tick;
            vectors++;
            if ({mult_mcand, mult_mlier, mult_mcand_is_signed, mult_mlier_is_signed} !== {3'd5, 4'd9, 1'b0, 1'b0}) begin
                miscompares++;
                $display("FAIL opchg_hold%0d: got %0d/%0d/%b/%b expected 5/9/0/0", k, mult_mcand, mult_mlier,
                         mult_mcand_is_signed, mult_mlier_is_signed);
            end
        end
        vectors++;
        if ({rsp_valid, rsp_id, rsp_prod} !== {1'b1, 2'd0, 7'd45}) begin
            miscompares++;
            $display("FAIL opchg_rsp: got valid=%b id=%0d prod=%0d expected valid=1 id=0 prod=45", rsp_valid, rsp_id, rsp_prod);
        end
        tick;
    endtask

    task automatic test_rotation;
        int   p, nacks, next_ack;
        logic [2:0] eack;
        rsp_t e;
        for (int i = 0; i < 3; i++) rand_ops(i);
        req = 3'b111;
        rst = 1'b1;
        tick;
        rst = 1'b0;
        exp_q.delete();
        p = 0;
        nacks = 0;
        next_ack = cyc + 1;
        for (int k = 0; k < 32; k++) begin
            tick;
            eack = (nacks < 4 && cyc == next_ack) ? onehot(p) : 3'b000;
            vectors++;
            if (req_ack !== eack) begin
                miscompares++;
                $display("FAIL rot_ack@%0d: got %b expected %b", k, req_ack, eack);
            end
            if (eack != 3'b000) begin
                vectors++;
                if ({mult_mcand, mult_mlier, mult_mcand_is_signed, mult_mlier_is_signed} !== {mc[p], ml[p], sc[p], sl[p]}) begin
                    miscompares++;
                    $display("FAIL rot_operands@%0d: got %b/%b expected %b/%b", k, mult_mcand, mult_mlier, mc[p], ml[p]);
                end
                e.cyc = cyc + 6;
                e.id = p;
                e.prod = ref_prod(mc[p], ml[p], sc[p], sl[p]);
                exp_q.push_back(e);
                rand_ops(p);
                p = (p + 1) % 3;
                nacks++;
                next_ack = cyc + 8;
                if (nacks == 4) req = '0;
            end
            if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
                e = exp_q.pop_front();
                vectors++;
                if ({rsp_valid, rsp_id, rsp_prod} !== {1'b1, 2'(e.id), e.prod}) begin
                    miscompares++;
                    $display("FAIL rot_rsp@%0d: got valid=%b id=%0d prod=%b expected valid=1 id=%0d prod=%b",
                             k, rsp_valid, rsp_id, rsp_prod, e.id, e.prod);
                end
            end else begin
                vectors++;
                if (rsp_valid !== 1'b0) begin
                    miscompares++;
                    $display("FAIL rot_rsp_idle@%0d: got valid=%b expected 0", k, rsp_valid);
                end
            end
        end
        vectors++;
        if (exp_q.size() != 0 || nacks != 4) begin
            miscompares++;
            $display("FAIL rot_complete: got acks=%0d pending=%0d expected acks=4 pending=0", nacks, exp_q.size());
        end
    endtask

    task automatic test_reset_mid_run;
        logic [6:0] ep;
        mc[0] = 3'd6;
        ml[0] = 4'd5;
        sc[0] = 1'b0;
        sl[0] = 1'b0;
        req = 3'b001;
        tick;
        vectors++;
        if (req_ack !== 3'b001) begin
            miscompares++;
            $display("FAIL rstrun_ack0: got %b expected 001", req_ack);
        end
        mc[1] = 3'b011;
        ml[1] = 4'b1010;
        sc[1] = 1'b0;
        sl[1] = 1'b1;
        ep = ref_prod(3'b011, 4'b1010, 1'b0, 1'b1);
        req = 3'b010;
        tick;
        tick;
        rst = 1'b1;
        #1;
        vectors++;
        if ({req_ack, rsp_valid, rsp_id, rsp_prod, mult_start, mult_mcand, mult_mlier,
             mult_mcand_is_signed, mult_mlier_is_signed} !== 23'd0) begin
            miscompares++;
            $display("FAIL rstrun_clear: got %h expected 0", {req_ack, rsp_valid, rsp_id, rsp_prod,
                     mult_start, mult_mcand, mult_mlier, mult_mcand_is_signed, mult_mlier_is_signed});
        end
        tick;
        vectors++;
        if ({req_ack, rsp_valid, mult_start} !== 5'b0) begin
            miscompares++;
            $display("FAIL rstrun_held: got ack=%b valid=%b start=%b expected all 0", req_ack, rsp_valid, mult_start);
        end
        rst = 1'b0;
        tick;
        vectors++;
        if ({req_ack, mult_mcand, mult_mlier} !== {3'b010, 3'b011, 4'b1010}) begin
            miscompares++;
            $display("FAIL rstrun_regrant: got ack=%b mcand=%b mlier=%b expected ack=010 mcand=011 mlier=1010",
                     req_ack, mult_mcand, mult_mlier);
        end
        req = '0;
        for (int k = 1; k <= 5; k++) begin
            tick;
            vectors++;
            if (rsp_valid !== 1'b0) begin
                miscompares++;
                $display("FAIL rstrun_norsp%0d: got valid=%b expected 0", k, rsp_valid);
            end
        end
        tick;
        vectors++;
        if ({rsp_valid, rsp_id, rsp_prod} !== {1'b1, 2'd1, ep}) begin
            miscompares++;
            $display("FAIL rstrun_rsp: got valid=%b id=%0d prod=%b expected valid=1 id=1 prod=%b", rsp_valid, rsp_id, rsp_prod, ep);
        end
        tick;
    endtask

    task automatic test_busy_hold;
        logic [6:0] ep;
        busy_force = 1'b1;
        mc[2] = 3'd3;
        ml[2] = 4'd7;
        sc[2] = 1'b1;
        sl[2] = 1'b0;
        ep = ref_prod(3'd3, 4'd7, 1'b1, 1'b0);
        req = 3'b100;
        for (int k = 1; k <= 3; k++) begin
            tick;
            vectors++;
            if (req_ack !== 3'b000) begin
                miscompares++;
                $display("FAIL busy_nogrant%0d: got %b expected 000", k, req_ack);
            end
        end
        busy_force = 1'b0;
        tick;
        vectors++;
        if (req_ack !== 3'b100) begin
            miscompares++;
            $display("FAIL busy_grant: got %b expected 100", req_ack);
        end
        req = '0;
        for (int k = 1; k <= 5; k++) tick;
        tick;
        vectors++;
        if ({rsp_valid, rsp_id, rsp_prod} !== {1'b1, 2'd2, ep}) begin
            miscompares++;
            $display("FAIL busy_rsp: got valid=%b id=%0d prod=%b expected valid=1 id=2 prod=%b", rsp_valid, rsp_id, rsp_prod, ep);
        end
        tick;
    endtask

    task automatic test_random_traffic;
        int   p, next_free, w;
        logic [2:0] eack;
        rsp_t e;
        req = '0;
        rst = 1'b1;
        tick;
        rst = 1'b0;
        exp_q.delete();
        p = 0;
        next_free = cyc + 1;
        for (int k = 0; k < 420; k++) begin
            tick;
            w = (cyc >= next_free && req != 3'b000) ? pick(req, p) : -1;
            eack = (w >= 0) ? onehot(w) : 3'b000;
            vectors++;
            if ({req_ack, mult_start} !== {eack, (w >= 0)}) begin
                miscompares++;
                $display("FAIL rnd_ack@%0d: got ack=%b start=%b expected ack=%b start=%b", k, req_ack, mult_start, eack, (w >= 0));
            end
            if (w >= 0) begin
                vectors++;
                if ({mult_mcand, mult_mlier, mult_mcand_is_signed, mult_mlier_is_signed} !== {mc[w], ml[w], sc[w], sl[w]}) begin
                    miscompares++;
                    $display("FAIL rnd_operands@%0d: got %b/%b/%b/%b expected %b/%b/%b/%b", k, mult_mcand, mult_mlier,
                             mult_mcand_is_signed, mult_mlier_is_signed, mc[w], ml[w], sc[w], sl[w]);
                end
                e.cyc = cyc + 6;
                e.id = w;
                e.prod = ref_prod(mc[w], ml[w], sc[w], sl[w]);
                exp_q.push_back(e);
                p = (w + 1) % 3;
                next_free = cyc + 8;
            end
            if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
                e = exp_q.pop_front();
                vectors++;
                if ({rsp_valid, rsp_id, rsp_prod} !== {1'b1, 2'(e.id), e.prod}) begin
                    miscompares++;
                    $display("FAIL rnd_rsp@%0d: got valid=%b id=%0d prod=%b expected valid=1 id=%0d prod=%b",
                             k, rsp_valid, rsp_id, rsp_prod, e.id, e.prod);
                end
            end else begin
                vectors++;
                if (rsp_valid !== 1'b0) begin
                    miscompares++;
                    $display("FAIL rnd_rsp_idle@%0d: got valid=%b expected 0", k, rsp_valid);
                end
            end
            for (int i = 0; i < 3; i++) begin
                if (req[i] && i == w) begin
                    req[i] = (k < 380) ? 1'($urandom_range(1)) : 1'b0;
                    rand_ops(i);
                end else if (!req[i] && k < 380 && $urandom_range(3) == 0) begin
                    req[i] = 1'b1;
                    rand_ops(i);
                end
            end
        end
        vectors++;
        if (exp_q.size() != 0 || req != 3'b000) begin
            miscompares++;
            $display("FAIL rnd_drain: got pending=%0d req=%b expected pending=0 req=000", exp_q.size(), req);
        end
    endtask

    initial begin
        test_reset;
        test_single_op("unsigned", 0, 3'd7, 4'd15, 1'b0, 1'b0);
        test_single_op("mixed_sign", 1, 3'b101, 4'b0110, 1'b1, 1'b0);
        test_single_op("both_signed", 2, 3'b111, 4'b1111, 1'b1, 1'b1);
        test_operand_change;
        test_rotation;
        test_reset_mid_run;
        test_busy_hold;
        test_random_traffic;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached before the summary");
        $fatal(1);
    end

endmodule
